// File: rtl/mux_arb_pkg.sv
// Shared constants for the mux_arb channel multiplexer/arbiter.
// Holds the MODE encodings and the default channel geometry.
package mux_arb_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_NCH    = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: the first requester after ptr_i (wrapping) wins.
// Produces a one-hot grant, its binary index and an any-grant flag.
module rr_arbiter #(
  parameter int NCH = 4,
  parameter int SW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req_i,
  input  logic [SW-1:0]  ptr_i,
  output logic [NCH-1:0] gnt_o,
  output logic [SW-1:0]  gnt_idx_o,
  output logic           gnt_valid_o
);

  localparam logic [NCH-1:0] ONE = NCH'(1);

  logic [NCH-1:0] hi_mask;
  logic [NCH-1:0] masked_req;
  logic [NCH-1:0] pick;

  // Channels strictly above the pointer get first look; otherwise wrap to the bottom.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_mask
    assign hi_mask[gi] = (SW'(gi) > ptr_i);
  end

  assign masked_req  = req_i & hi_mask;
  assign pick        = (|masked_req) ? masked_req : req_i;
  assign gnt_o       = pick & (~pick + ONE);
  assign gnt_valid_o = |req_i;

  always_comb begin
    gnt_idx_o = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt_o[i]) begin
        gnt_idx_o = SW'(i);
      end
    end
  end

endmodule

// File: rtl/mux_arb.sv
// N-channel to one multiplexer with a single registered output stage.
// Channel choice is either a fixed sel index or round-robin arbitration.
module mux_arb
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH   = DEF_NCH,
  parameter int MODE  = MODE_FIXED,
  parameter int SW    = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [SW-1:0]        sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SW-1:0]        out_ch
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SW-1:0]    out_ch_q,   out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [SW-1:0]    ptr_q,      ptr_d;

  logic             le;
  logic [NCH-1:0]   fixed_gnt;
  logic [NCH-1:0]   rr_gnt;
  logic [SW-1:0]    rr_idx;
  logic             rr_any;
  logic [NCH-1:0]   gnt_vec;
  logic [SW-1:0]    gnt_idx;
  logic             gnt_any;
  logic [WIDTH-1:0] gnt_word;

  assign le = !out_valid_q || out_ready;

  // An out-of-range sel matches no channel, so it naturally yields no grant.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_fixed
    assign fixed_gnt[gi] = in_valid[gi] && (sel == SW'(gi));
  end

  rr_arbiter #(
    .NCH (NCH),
    .SW  (SW)
  ) u_rr_arbiter (
    .req_i       (in_valid),
    .ptr_i       (ptr_q),
    .gnt_o       (rr_gnt),
    .gnt_idx_o   (rr_idx),
    .gnt_valid_o (rr_any)
  );

  assign gnt_vec = (MODE == MODE_RR) ? rr_gnt : fixed_gnt;
  assign gnt_idx = (MODE == MODE_RR) ? rr_idx : sel;
  assign gnt_any = (MODE == MODE_RR) ? rr_any : (|fixed_gnt);

  always_comb begin
    gnt_word = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt_vec[i]) begin
        gnt_word = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Gated by rst so no channel sees an accept while the block is held in reset.
  assign in_ready = (le && !rst) ? gnt_vec : '0;

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (le) begin
      out_valid_d = gnt_any;
      if (gnt_any) begin
        out_data_d = gnt_word;
        out_ch_d   = gnt_idx;
        ptr_d      = gnt_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= SW'(NCH - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_arb.sv
// Directed bench for mux_arb: fixed-select (NCH=4 and NCH=3) and round-robin instances
// sharing one clock and reset, checked with immediate assertions.
module tb_mux_arb;

  logic clk;
  logic rst;

  // fixed-select, NCH=4
  logic [63:0] f_in_data;
  logic [3:0]  f_in_valid, f_in_ready;
  logic [1:0]  f_sel, f_out_ch;
  logic [15:0] f_out_data;
  logic        f_out_valid, f_out_ready;

  // round-robin, NCH=4
  logic [63:0] r_in_data;
  logic [3:0]  r_in_valid, r_in_ready;
  logic [1:0]  r_sel, r_out_ch;
  logic [15:0] r_out_data;
  logic        r_out_valid, r_out_ready;

  // fixed-select, NCH=3
  logic [47:0] t_in_data;
  logic [2:0]  t_in_valid, t_in_ready;
  logic [1:0]  t_sel, t_out_ch;
  logic [15:0] t_out_data;
  logic        t_out_valid, t_out_ready;

  int checks = 0;
  int errors = 0;

  mux_arb #(.WIDTH(16), .NCH(4), .MODE(0)) u_fix (
    .clk(clk), .rst(rst), .in_data(f_in_data), .in_valid(f_in_valid), .in_ready(f_in_ready),
    .sel(f_sel), .out_data(f_out_data), .out_valid(f_out_valid), .out_ready(f_out_ready),
    .out_ch(f_out_ch)
  );

  mux_arb #(.WIDTH(16), .NCH(4), .MODE(1)) u_rr (
    .clk(clk), .rst(rst), .in_data(r_in_data), .in_valid(r_in_valid), .in_ready(r_in_ready),
    .sel(r_sel), .out_data(r_out_data), .out_valid(r_out_valid), .out_ready(r_out_ready),
    .out_ch(r_out_ch)
  );

  mux_arb #(.WIDTH(16), .NCH(3), .MODE(0)) u_fix3 (
    .clk(clk), .rst(rst), .in_data(t_in_data), .in_valid(t_in_valid), .in_ready(t_in_ready),
    .sel(t_sel), .out_data(t_out_data), .out_valid(t_out_valid), .out_ready(t_out_ready),
    .out_ch(t_out_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    f_in_data = '0; f_in_valid = '0; f_sel = '0; f_out_ready = 1'b1;
    r_in_data = '0; r_in_valid = '0; r_sel = '0; r_out_ready = 1'b1;
    t_in_data = '0; t_in_valid = '0; t_sel = '0; t_out_ready = 1'b1;

    // reset state, with a valid request pending to prove in_ready is held low
    f_sel = 2'd2; f_in_valid = 4'b0100; f_in_data[2*16 +: 16] = 16'hBEEF;
    #3;
    chk("rst_out_valid", {31'd0, f_out_valid}, 32'd0);
    chk("rst_out_data",  {16'd0, f_out_data}, 32'd0);
    chk("rst_out_ch",    {30'd0, f_out_ch}, 32'd0);
    chk("rst_in_ready",  {28'd0, f_in_ready}, 32'd0);
    step();
    rst = 1'b0;
    #1;

    // fixed select sel=2
    chk("fix_in_ready_sel2", {28'd0, f_in_ready}, 32'h4);
    step();
    chk("fix_out_data_beef", {16'd0, f_out_data}, 32'hBEEF);
    chk("fix_out_ch_2",      {30'd0, f_out_ch}, 32'd2);
    chk("fix_out_valid",     {31'd0, f_out_valid}, 32'd1);

    // backpressure for 3 cycles while sel wanders
    f_out_ready = 1'b0;
    f_in_valid = 4'b0011;
    f_in_data[1*16 +: 16] = 16'h1111;
    f_in_data[0*16 +: 16] = 16'h0000;
    for (int c = 0; c < 3; c++) begin
      f_sel = c[1:0];
      #1;
      chk("bp_in_ready", {28'd0, f_in_ready}, 32'd0);
      step();
      chk("bp_out_data",  {16'd0, f_out_data}, 32'hBEEF);
      chk("bp_out_ch",    {30'd0, f_out_ch}, 32'd2);
      chk("bp_out_valid", {31'd0, f_out_valid}, 32'd1);
    end
    f_sel = 2'd1;
    f_out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", {28'd0, f_in_ready}, 32'h2);
    step();
    chk("bp_replace_data",  {16'd0, f_out_data}, 32'h1111);
    chk("bp_replace_ch",    {30'd0, f_out_ch}, 32'd1);
    chk("bp_replace_valid", {31'd0, f_out_valid}, 32'd1);
    f_in_valid = 4'b0000;
    step();
    chk("fix_drain_valid", {31'd0, f_out_valid}, 32'd0);
    chk("fix_drain_hold",  {16'd0, f_out_data}, 32'h1111);

    // round-robin, all channels requesting for 8 cycles
    r_in_data = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    r_in_valid = 4'b1111;
    #1;
    chk("rr_first_ready", {28'd0, r_in_ready}, 32'h1);
    for (int c = 0; c < 8; c++) begin
      step();
      chk("rr_seq_ch",    {30'd0, r_out_ch}, 32'(c % 4));
      chk("rr_seq_data",  {16'd0, r_out_data}, 32'h0000A000 + 32'(c % 4));
      chk("rr_seq_valid", {31'd0, r_out_valid}, 32'd1);
    end

    // sparse: ptr=3 -> grant 0 sets ptr=0, then 3, 0, 3
    r_in_valid = 4'b1001;
    step();
    chk("rr_sparse_setup", {30'd0, r_out_ch}, 32'd0);
    step();
    chk("rr_sparse_a", {30'd0, r_out_ch}, 32'd3);
    step();
    chk("rr_sparse_b", {30'd0, r_out_ch}, 32'd0);
    step();
    chk("rr_sparse_c", {30'd0, r_out_ch}, 32'd3);
    r_in_valid = 4'b0000;
    #1;
    chk("rr_idle_ready", {28'd0, r_in_ready}, 32'd0);
    step();
    chk("rr_idle_valid", {31'd0, r_out_valid}, 32'd0);
    chk("rr_idle_ch",    {30'd0, r_out_ch}, 32'd3);
    r_in_valid = 4'b1111;
    #1;
    chk("rr_ptr_held", {28'd0, r_in_ready}, 32'h1);
    r_in_valid = 4'b0000;

    // NCH=3 with out-of-range sel
    t_in_data = {16'h5555, 16'h4444, 16'h3333};
    t_sel = 2'd0; t_in_valid = 3'b001;
    step();
    chk("n3_load_valid", {31'd0, t_out_valid}, 32'd1);
    chk("n3_load_data",  {16'd0, t_out_data}, 32'h3333);
    t_out_ready = 1'b0; t_sel = 2'd3; t_in_valid = 3'b111;
    step();
    chk("n3_hold_valid", {31'd0, t_out_valid}, 32'd1);
    chk("n3_hold_data",  {16'd0, t_out_data}, 32'h3333);
    t_out_ready = 1'b1;
    #1;
    chk("n3_sel3_ready", {29'd0, t_in_ready}, 32'd0);
    step();
    chk("n3_drain_valid", {31'd0, t_out_valid}, 32'd0);
    chk("n3_drain_data",  {16'd0, t_out_data}, 32'h3333);

    // asynchronous reset mid-stream, then channel 0 wins first
    r_in_valid = 4'b0010;
    step();
    chk("rst_pre_valid", {31'd0, r_out_valid}, 32'd1);
    chk("rst_pre_ch",    {30'd0, r_out_ch}, 32'd1);
    r_in_valid = 4'b0000;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, r_out_valid}, 32'd0);
    chk("arst_data",  {16'd0, r_out_data}, 32'd0);
    chk("arst_ch",    {30'd0, r_out_ch}, 32'd0);
    r_in_valid = 4'b1111;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {28'd0, r_in_ready}, 32'h1);
    step();
    chk("post_rst_ch",    {30'd0, r_out_ch}, 32'd0);
    chk("post_rst_data",  {16'd0, r_out_data}, 32'hA000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
